iic_arbiter: RTL and testbench
==============================

IIC_ARBITER -- requirements
Module: iic_arbiter

Interface
REQ-001 SHALL have parameter C_TIMEOUT, default 20'd200000: the number of I_clk cycles a granted transaction may run before it is aborted.
REQ-002 SHALL have parameter C_GAP, default 8'd10: the number of I_clk cycles the engine enable is held low between transactions.
REQ-003 SHALL have port I_clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port I_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port I_req, input, 4 bits: per-requester transaction request, level, held until that requester's ack or err.
REQ-006 SHALL have port I_dev_addr_bus, input, 28 bits: 7-bit device address per requester; requester n uses bits [7n+6:7n].
REQ-007 SHALL have port I_word_addr_bus, input, 32 bits: 8-bit word address per requester; requester n uses bits [8n+7:8n].
REQ-008 SHALL have port O_grant, output, 4 bits: one-hot owner of the engine, all zero when nobody owns it.
REQ-009 SHALL have port O_ack, output, 4 bits: one-cycle completion pulse to the owning requester.
REQ-010 SHALL have port O_err, output, 4 bits: one-cycle timeout pulse to the owning requester.
REQ-011 SHALL have port O_rd_data, output, 8 bits: the last successfully read byte.
REQ-012 SHALL have port O_busy, output, 1 bit: high in every state except IDLE.
REQ-013 SHALL have port O_iic_recv_en, output, 1 bit: enable to the IIC read engine.
REQ-014 SHALL have port O_dev_addr, output, 7 bits: device address to the engine.
REQ-015 SHALL have port O_word_addr, output, 8 bits: word address to the engine.
REQ-016 SHALL have port I_read_data, input, 8 bits: the byte read by the engine.
REQ-017 SHALL have port I_done_flag, input, 1 bit: the engine's one-cycle done pulse.

Function
REQ-018 SHALL implement four states, IDLE, ARB, RUN and GAP, with every output registered.
REQ-019 In IDLE, SHALL move to ARB when I_req is non-zero, and otherwise stay in IDLE.
REQ-020 In ARB (one cycle), SHALL pick the winner round-robin, searching upward from last_grant+1 with wrap 3->0.
- last_grant resets to 3, so requester 0 wins first.
REQ-021 In ARB, SHALL latch the winner's address fields into O_dev_addr/O_word_addr, set O_grant one-hot, set O_iic_recv_en=1, clear the timeout counter, and enter RUN.
- O_grant and O_iic_recv_en therefore rise together, 2 clocks after I_req is first sampled high in IDLE.
REQ-022 If I_req has dropped to zero by the ARB cycle, SHALL return to IDLE with no grant.
REQ-023 O_dev_addr/O_word_addr SHALL stay stable for the whole of RUN; input bus changes during RUN SHALL be ignored.
REQ-024 In RUN, the timeout counter (20 bits) SHALL increment once per cycle.
REQ-025 On I_done_flag=1 in RUN, SHALL on the next edge: load O_rd_data from I_read_data, pulse O_ack[owner] for one cycle, update last_grant to the owner, drop O_iic_recv_en, clear O_grant, and enter GAP.
REQ-026 When the counter reaches C_TIMEOUT-1 without done, SHALL pulse O_err[owner] for one cycle, leave O_rd_data unchanged, update last_grant, drop the enable and the grant, and enter GAP.
- This is required because the engine retries indefinitely on NACK and never asserts done.
REQ-027 If done and timeout occur in the same cycle, done SHALL win: ack is issued and err is not.
REQ-028 I_done_flag outside RUN SHALL be ignored.
REQ-029 A requester dropping I_req during RUN SHALL NOT abort the transaction; its ack/err is still issued.
REQ-030 In GAP, SHALL hold O_iic_recv_en=0 for exactly C_GAP cycles (counted by an 8-bit counter), then enter IDLE.
- C_GAP=0 SHALL be treated as 1, so that the engine always sees the enable low for at least one cycle and returns to its idle state.
REQ-031 O_ack and O_err SHALL be mutually exclusive, at most one bit set, and only in the first GAP cycle.
REQ-032 A requester SHALL NOT be granted twice in a row while another requester is waiting.

Reset
REQ-033 While I_rst_n=0, SHALL asynchronously force the following, at any time including mid-RUN, with no ack or err issued for the aborted transaction:
- state = IDLE;
- O_grant, O_ack and O_err = 0;
- O_rd_data = 0, O_busy = 0, O_iic_recv_en = 0;
- O_dev_addr = 0, O_word_addr = 0;
- both counters = 0;
- last_grant = 3.

Verification
REQ-034 Single request: I_req=4'b0100, dev 7'h50, word 8'h12; engine model returns done with 8'hA5 after 3000 cycles -> O_grant=4'b0100 and enable high 2 clocks after I_req; O_dev_addr=7'h50, O_word_addr=8'h12; O_ack=4'b0100 for 1 cycle; O_rd_data=8'hA5; enable low for 10 cycles; O_busy low afterwards.
REQ-035 Fairness: I_req=4'b1111 held, each requester dropping its request after its ack -> grant order 0,1,2,3, four acks, a GAP of 10 cycles between each transaction.
REQ-036 Timeout: C_TIMEOUT=100, engine never asserts done -> O_err[owner] pulses once, 100 cycles after enable rose; O_rd_data keeps its previous value; the next requester is served afterwards.
REQ-037 Collision: done and timeout in the same cycle -> O_ack pulses; O_err stays 0.
REQ-038 Reset mid-RUN: I_rst_n low 5 cycles into RUN -> all outputs 0 immediately; after release with I_req=4'b1000 pending -> requester 3 is granted after the normal ARB sequence.
REQ-039 Drop/ignore: I_req dropped during RUN and a spurious I_done_flag in IDLE -> the RUN transaction still completes with its ack; the spurious done causes no state change and no ack.

Source files
------------

// File: rtl/iic_arbiter.sv
// Round-robin arbiter that shares one IIC read engine among four requesters.
// Each grant runs one read; a watchdog aborts reads the engine never finishes.
module iic_arbiter #(
  parameter logic [19:0] C_TIMEOUT = 20'd200000,
  parameter logic [7:0]  C_GAP     = 8'd10
) (
  input  logic        I_clk,
  input  logic        I_rst_n,
  input  logic [3:0]  I_req,
  input  logic [27:0] I_dev_addr_bus,
  input  logic [31:0] I_word_addr_bus,
  output logic [3:0]  O_grant,
  output logic [3:0]  O_ack,
  output logic [3:0]  O_err,
  output logic [7:0]  O_rd_data,
  output logic        O_busy,
  output logic        O_iic_recv_en,
  output logic [6:0]  O_dev_addr,
  output logic [7:0]  O_word_addr,
  input  logic [7:0]  I_read_data,
  input  logic        I_done_flag
);

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_RUN, S_GAP} state_t;

  // A zero gap still drops the enable for one cycle so the engine can re-arm.
  localparam logic [7:0] GAP_LAST = (C_GAP == 8'd0) ? 8'd0 : C_GAP - 8'd1;

  state_t      state, state_nxt;
  logic [1:0]  last_grant, last_nxt;
  logic [1:0]  owner, owner_nxt;
  logic [19:0] to_cnt, to_nxt;
  logic [7:0]  gap_cnt, gap_nxt;

  logic [3:0]  grant_nxt, ack_nxt, err_nxt;
  logic [7:0]  rd_nxt, word_nxt;
  logic [6:0]  dev_nxt;
  logic        en_nxt, busy_nxt;

  logic [1:0]  cand;
  logic [1:0]  win_idx;
  logic        win_found;
  logic [6:0]  dev_sel;
  logic [7:0]  word_sel;

  // Search upward from the previous owner; the previous owner is tried last.
  always_comb begin
    cand      = 2'd0;
    win_idx   = 2'd0;
    win_found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cand = last_grant + 2'(i);
      if (!win_found && I_req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign dev_sel  = I_dev_addr_bus[7*win_idx +: 7];
  assign word_sel = I_word_addr_bus[8*win_idx +: 8];

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    state_nxt = state;
    last_nxt  = last_grant;
    owner_nxt = owner;
    to_nxt    = to_cnt;
    gap_nxt   = gap_cnt;
    grant_nxt = O_grant;
    ack_nxt   = 4'b0000;
    err_nxt   = 4'b0000;
    rd_nxt    = O_rd_data;
    en_nxt    = O_iic_recv_en;
    dev_nxt   = O_dev_addr;
    word_nxt  = O_word_addr;

    case (state)
      S_IDLE: begin
        if (|I_req) state_nxt = S_ARB;
      end
      S_ARB: begin
        if (win_found) begin
          owner_nxt = win_idx;
          grant_nxt = 4'b0001 << win_idx;
          dev_nxt   = dev_sel;
          word_nxt  = word_sel;
          en_nxt    = 1'b1;
          to_nxt    = 20'd0;
          state_nxt = S_RUN;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        to_nxt = to_cnt + 20'd1;
        if (I_done_flag || (to_cnt == C_TIMEOUT - 20'd1)) begin
          last_nxt  = owner;
          grant_nxt = 4'b0000;
          en_nxt    = 1'b0;
          gap_nxt   = 8'd0;
          state_nxt = S_GAP;
          // Done beats a simultaneous timeout.
          if (I_done_flag) begin
            rd_nxt  = I_read_data;
            ack_nxt = 4'b0001 << owner;
          end else begin
            err_nxt = 4'b0001 << owner;
          end
        end
      end
      S_GAP: begin
        gap_nxt = gap_cnt + 8'd1;
        if (gap_cnt >= GAP_LAST) begin
          gap_nxt   = 8'd0;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    busy_nxt = (state_nxt != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state         <= S_IDLE;
      last_grant    <= 2'd3;
      owner         <= 2'd0;
      to_cnt        <= 20'd0;
      gap_cnt       <= 8'd0;
      O_grant       <= 4'b0000;
      O_ack         <= 4'b0000;
      O_err         <= 4'b0000;
      O_rd_data     <= 8'd0;
      O_busy        <= 1'b0;
      O_iic_recv_en <= 1'b0;
      O_dev_addr    <= 7'd0;
      O_word_addr   <= 8'd0;
    end else begin
      state         <= state_nxt;
      last_grant    <= last_nxt;
      owner         <= owner_nxt;
      to_cnt        <= to_nxt;
      gap_cnt       <= gap_nxt;
      O_grant       <= grant_nxt;
      O_ack         <= ack_nxt;
      O_err         <= err_nxt;
      O_rd_data     <= rd_nxt;
      O_busy        <= busy_nxt;
      O_iic_recv_en <= en_nxt;
      O_dev_addr    <= dev_nxt;
      O_word_addr   <= word_nxt;
    end
  end

endmodule

// File: tb/tb_iic_arbiter.sv
// Directed bench for iic_arbiter: dut_a uses default parameters, dut_b a short
// timeout; completions are compared against a queue of expected responses.
module tb_iic_arbiter;

  localparam int GAP = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [27:0] dev_bus;
  logic [31:0] word_bus;
  logic [7:0]  rdata;

  logic [3:0] a_req, a_grant, a_ack, a_err;
  logic       a_done, a_busy, a_en;
  logic [7:0] a_rd, a_word;
  logic [6:0] a_dev;

  logic [3:0] b_req, b_grant, b_ack, b_err;
  logic       b_done, b_busy, b_en;
  logic [7:0] b_rd, b_word;
  logic [6:0] b_dev;

  iic_arbiter dut_a (
    .I_clk(clk), .I_rst_n(rst_n), .I_req(a_req),
    .I_dev_addr_bus(dev_bus), .I_word_addr_bus(word_bus),
    .O_grant(a_grant), .O_ack(a_ack), .O_err(a_err), .O_rd_data(a_rd),
    .O_busy(a_busy), .O_iic_recv_en(a_en), .O_dev_addr(a_dev),
    .O_word_addr(a_word), .I_read_data(rdata), .I_done_flag(a_done)
  );

  iic_arbiter #(.C_TIMEOUT(20'd100)) dut_b (
    .I_clk(clk), .I_rst_n(rst_n), .I_req(b_req),
    .I_dev_addr_bus(dev_bus), .I_word_addr_bus(word_bus),
    .O_grant(b_grant), .O_ack(b_ack), .O_err(b_err), .O_rd_data(b_rd),
    .O_busy(b_busy), .O_iic_recv_en(b_en), .O_dev_addr(b_dev),
    .O_word_addr(b_word), .I_read_data(rdata), .I_done_flag(b_done)
  );

  typedef struct packed {
    logic [3:0] ack;
    logic [3:0] err;
    logic [7:0] rd;
  } resp_t;

  resp_t sb_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_addrs();
    for (int i = 0; i < 4; i++) begin
      dev_bus[7*i +: 7]  = 7'h10 + 7'(i);
      word_bus[8*i +: 8] = 8'h80 + 8'(i);
    end
  endtask

  // Engine model: one-cycle done pulse carrying the read byte.
  task automatic pulse_done(input bit use_b, input logic [7:0] d, input logic [3:0] exp_ack);
    sb_q.push_back('{ack: exp_ack, err: 4'b0000, rd: d});
    rdata = d;
    if (use_b) b_done = 1'b1; else a_done = 1'b1;
    tick();
    a_done = 1'b0;
    b_done = 1'b0;
  endtask

  task automatic wait_grant(input bit use_b, input int bound, output int waited);
    logic [3:0] g;
    waited = 0;
    g = use_b ? b_grant : a_grant;
    while (g == 4'b0000 && waited < bound) begin
      tick();
      waited++;
      g = use_b ? b_grant : a_grant;
    end
  endtask

  task automatic wait_resp(input string tag, input bit use_b, input int bound, output int waited);
    logic [3:0] ack, err;
    logic [7:0] rd;
    resp_t      e;
    waited = 0;
    ack = use_b ? b_ack : a_ack;
    err = use_b ? b_err : a_err;
    while ((ack | err) == 4'b0000 && waited < bound) begin
      tick();
      waited++;
      ack = use_b ? b_ack : a_ack;
      err = use_b ? b_err : a_err;
    end
    rd = use_b ? b_rd : a_rd;
    check({tag, "_seen"}, 32'(|(ack | err)), 32'd1);
    e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
    check({tag, "_ack"}, 32'(ack), 32'(e.ack));
    check({tag, "_err"}, 32'(err), 32'(e.err));
    check({tag, "_rd"},  32'(rd),  32'(e.rd));
  endtask

  task automatic wait_idle(input string tag, input bit use_b, input int bound);
    int n = 0;
    while ((use_b ? b_busy : a_busy) && n < bound) begin
      tick();
      n++;
    end
    check({tag, "_idle"}, 32'(use_b ? b_busy : a_busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, n, en_hi, seen;
    rst_n = 1'b0; a_req = '0; b_req = '0; a_done = 1'b0; b_done = 1'b0;
    dev_bus = '0; word_bus = '0; rdata = '0;
    repeat (3) tick();

    // Reset state
    check("rst_grant", 32'(a_grant), 32'd0);
    check("rst_busy",  32'(a_busy),  32'd0);
    check("rst_en",    32'(a_en),    32'd0);
    check("rst_rd",    32'(a_rd),    32'd0);
    check("rst_ackerr", 32'({a_ack, a_err}), 32'd0);
    rst_n = 1'b1;
    tick();

    // Fairness: all four request, each drops after its ack
    set_addrs();
    a_req = 4'hF;
    for (int i = 0; i < 4; i++) begin
      wait_grant(1'b0, 40, w);
      check($sformatf("fair_grant%0d", i), 32'(a_grant), 32'(4'b0001 << i));
      check($sformatf("fair_dev%0d", i),  32'(a_dev),  32'(7'h10 + 7'(i)));
      check($sformatf("fair_word%0d", i), 32'(a_word), 32'(8'h80 + 8'(i)));
      // From ack: GAP cycles, then one IDLE and one ARB cycle before the grant.
      check($sformatf("fair_wait%0d", i), 32'(w), (i == 0) ? 32'd2 : 32'(GAP + 2));
      repeat (5) tick();
      pulse_done(1'b0, 8'hC0 + 8'(i), 4'b0001 << i);
      wait_resp($sformatf("fair_resp%0d", i), 1'b0, 4, w);
      a_req[i] = 1'b0;
    end
    wait_idle("fair", 1'b0, 40);

    // Single request, engine answers after 3000 cycles
    dev_bus[20:14]  = 7'h50;
    word_bus[23:16] = 8'h12;
    a_req = 4'b0100;
    tick();
    check("single_arb_grant", 32'(a_grant), 32'd0);
    check("single_arb_busy",  32'(a_busy),  32'd1);
    tick();
    check("single_grant", 32'(a_grant), 32'h4);
    check("single_en",    32'(a_en),    32'd1);
    check("single_dev",   32'(a_dev),   32'h50);
    check("single_word",  32'(a_word),  32'h12);
    dev_bus  = '1;
    word_bus = '1;
    repeat (2999) tick();
    check("single_dev_stable",  32'(a_dev),  32'h50);
    check("single_word_stable", 32'(a_word), 32'h12);
    pulse_done(1'b0, 8'hA5, 4'b0100);
    wait_resp("single", 1'b0, 4, w);
    a_req = 4'b0000;
    check("single_en_drop", 32'(a_en), 32'd0);
    tick();
    check("single_ack_1cyc", 32'(a_ack), 32'd0);
    n = 1;
    en_hi = 0;
    while (a_busy && n < 50) begin
      if (a_en) en_hi++;
      tick();
      n++;
    end
    check("single_gap_len", 32'(n), 32'(GAP));
    check("single_gap_en",  32'(en_hi), 32'd0);
    check("single_busy_low", 32'(a_busy), 32'd0);
    check("single_rd_hold", 32'(a_rd), 32'hA5);

    // Reset mid-RUN
    set_addrs();
    a_req = 4'b0010;
    wait_grant(1'b0, 10, w);
    check("rstrun_grant", 32'(a_grant), 32'h2);
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    check("rstrun_grant0", 32'(a_grant), 32'd0);
    check("rstrun_en0",    32'(a_en),    32'd0);
    check("rstrun_busy0",  32'(a_busy),  32'd0);
    check("rstrun_addr0",  32'({a_dev, a_word}), 32'd0);
    check("rstrun_rd0",    32'(a_rd),    32'd0);
    a_req = 4'b1000;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      seen = seen | int'({a_ack, a_err});
    end
    check("rstrun_no_resp", 32'(seen), 32'd0);
    rst_n = 1'b1;
    tick();
    check("rstrun_arb_grant", 32'(a_grant), 32'd0);
    check("rstrun_arb_busy",  32'(a_busy),  32'd1);
    tick();
    check("rstrun_regrant", 32'(a_grant), 32'h8);
    check("rstrun_dev",     32'(a_dev),   32'h13);
    pulse_done(1'b0, 8'h77, 4'b1000);
    wait_resp("rstrun", 1'b0, 4, w);
    a_req = 4'b0000;
    wait_idle("rstrun", 1'b0, 40);

    // Spurious done in IDLE, then request dropped during RUN
    rdata  = 8'hEE;
    a_done = 1'b1;
    tick();
    a_done = 1'b0;
    check("spur_busy", 32'(a_busy), 32'd0);
    check("spur_rd",   32'(a_rd),   32'h77);
    tick();
    check("spur_ack", 32'({a_ack, a_err}), 32'd0);
    a_req = 4'b0001;
    wait_grant(1'b0, 10, w);
    check("drop_grant", 32'(a_grant), 32'h1);
    a_req = 4'b0000;
    repeat (4) tick();
    check("drop_grant_held", 32'(a_grant), 32'h1);
    check("drop_en_held",    32'(a_en),    32'd1);
    pulse_done(1'b0, 8'h3C, 4'b0001);
    wait_resp("drop", 1'b0, 4, w);

    // Timeout on dut_b (C_TIMEOUT=100): first a good read to set rd_data
    b_req = 4'b0001;
    wait_grant(1'b1, 10, w);
    check("to_first_grant", 32'(b_grant), 32'h1);
    repeat (3) tick();
    pulse_done(1'b1, 8'h5A, 4'b0001);
    wait_resp("to_first", 1'b1, 4, w);
    b_req = 4'b0110;
    wait_grant(1'b1, 40, w);
    check("to_grant", 32'(b_grant), 32'h2);
    check("to_en",    32'(b_en),    32'd1);
    sb_q.push_back('{ack: 4'b0000, err: 4'b0010, rd: 8'h5A});
    wait_resp("to", 1'b1, 200, w);
    check("to_latency", 32'(w), 32'd100);
    b_req[1] = 1'b0;
    tick();
    check("to_err_1cyc", 32'(b_err), 32'd0);
    wait_grant(1'b1, 40, w);
    check("to_next_grant", 32'(b_grant), 32'h4);

    // Collision: done arrives on the same edge the timeout fires
    repeat (99) tick();
    pulse_done(1'b1, 8'h5B, 4'b0100);
    wait_resp("coll", 1'b1, 2, w);
    b_req = 4'b0000;
    tick();
    check("coll_err_after", 32'({b_ack, b_err}), 32'd0);
    wait_idle("coll", 1'b1, 40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
